// File: rtl/decode_stage.sv
//-----------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//    Single-register RISC-V decode stage. An accepted instruction word is
//    split into its fields, classified into an instruction format and given
//    a sign-extended immediate. The results appear one cycle after acceptance
//    and are held while the consumer stalls.
//
// Parameters:
//    XLEN  - datapath width, 32 or 64. RV64-only opcodes (OP-32, OP-IMM-32)
//            are decoded only when XLEN=64.
//
// Optional feature:
//    DECODE_ILLEGAL_CHECK_EN - when defined, out_illegal flags malformed
//            encodings. When undefined, out_illegal is tied to 0 and the
//            check logic is absent.
//
// Ports:
//    clk            i  clock, all state changes on the rising edge
//    rst_n          i  asynchronous active-low reset
//    flush          i  discards the held instruction at the next edge
//    in_valid       i  upstream handshake: instruction available
//    in_ready       o  upstream handshake: stage can accept
//    in_instr       i  32-bit instruction word
//    in_pc          i  instruction address (XLEN)
//    out_valid      o  downstream handshake: decoded result available
//    out_ready      i  downstream handshake: consumer takes the result
//    out_instr      o  registered instruction word
//    out_pc         o  registered instruction address
//    out_rs1/rs2    o  source register indices (raw fields)
//    out_rd         o  destination index, 0 for S/B/invalid formats
//    out_opcode     o  instr[6:0]
//    out_funct3     o  instr[14:12]
//    out_funct7     o  instr[31:25]
//    out_imm        o  sign-extended immediate (XLEN)
//    out_fmt        o  format: R=0 I=1 S=2 B=3 U=4 J=5 invalid=7
//    out_rd_we      o  register write enable
//    out_illegal    o  illegal-encoding flag
//    decoded_count  o  number of delivered instructions (wraps)
//-----------------------------------------------------------------------------
module decode_stage #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [4:0]      out_rd,
   output logic [6:0]      out_opcode,
   output logic [2:0]      out_funct3,
   output logic [6:0]      out_funct7,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_rd_we,
   output logic            out_illegal,
   output logic [31:0]     decoded_count
);

   localparam logic [2:0] FMT_R   = 3'd0;
   localparam logic [2:0] FMT_I   = 3'd1;
   localparam logic [2:0] FMT_S   = 3'd2;
   localparam logic [2:0] FMT_B   = 3'd3;
   localparam logic [2:0] FMT_U   = 3'd4;
   localparam logic [2:0] FMT_J   = 3'd5;
   localparam logic [2:0] FMT_INV = 3'd7;

   localparam bit IS_RV64 = (XLEN == 64);

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_REG32  = 7'b0111011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   //--------------------------------------------------------------------------
   // Output register
   //--------------------------------------------------------------------------
   logic            r_valid;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_pc;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   logic [6:0]      r_opcode;
   logic [2:0]      r_funct3;
   logic [6:0]      r_funct7;
   logic [XLEN-1:0] r_imm;
   logic [2:0]      r_fmt;
   logic            r_rd_we;
   logic            r_illegal;
   logic [31:0]     r_count;

   //--------------------------------------------------------------------------
   // Combinational decode of the incoming word
   //--------------------------------------------------------------------------
   logic [6:0]      w_opcode;
   logic [2:0]      w_funct3;
   logic [6:0]      w_funct7;
   logic [4:0]      w_rd_raw;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [2:0]      w_fmt;
   logic [31:0]     w_imm32;
   logic [XLEN-1:0] w_imm;
   logic            w_writes_rd;
   logic [4:0]      w_rd;
   logic            w_rd_we;
   logic            w_illegal;
   logic            w_accept;
   logic            w_deliver;

   assign w_opcode = in_instr[6:0];
   assign w_rd_raw = in_instr[11:7];
   assign w_funct3 = in_instr[14:12];
   assign w_rs1    = in_instr[19:15];
   assign w_rs2    = in_instr[24:20];
   assign w_funct7 = in_instr[31:25];

   // Format classification; RV64-only opcodes fall through to invalid on RV32.
   always_comb begin
      w_fmt = FMT_INV;
      case (w_opcode)
         OP_REG:                                w_fmt = FMT_R;
         OP_REG32:                              if (IS_RV64) w_fmt = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:   w_fmt = FMT_I;
         OP_IMM32:                              if (IS_RV64) w_fmt = FMT_I;
         OP_STORE:                              w_fmt = FMT_S;
         OP_BRANCH:                             w_fmt = FMT_B;
         OP_LUI, OP_AUIPC:                      w_fmt = FMT_U;
         OP_JAL:                                w_fmt = FMT_J;
         default:                               w_fmt = FMT_INV;
      endcase
   end

   // 32-bit immediate, already sign-extended from instr[31] where applicable.
   always_comb begin
      w_imm32 = 32'd0;
      case (w_fmt)
         FMT_I: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: w_imm32 = {in_instr[31:12], 12'd0};
         FMT_J: w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
         default: w_imm32 = 32'd0;
      endcase
   end

   // Widen to XLEN; R/invalid produce 0 so the extension stays 0 as well.
   generate
      if (XLEN > 32) begin : g_imm_wide
         assign w_imm = {{(XLEN-32){w_imm32[31]}}, w_imm32};
      end else begin : g_imm_narrow
         assign w_imm = w_imm32;
      end
   endgenerate

   // Only R/I/U/J carry a destination; x0 is never written.
   assign w_writes_rd = (w_fmt == FMT_R) || (w_fmt == FMT_I) ||
                        (w_fmt == FMT_U) || (w_fmt == FMT_J);
   assign w_rd        = w_writes_rd ? w_rd_raw : 5'd0;
   assign w_rd_we     = w_writes_rd && (w_rd_raw != 5'd0);

`ifdef DECODE_ILLEGAL_CHECK_EN
   always_comb begin
      w_illegal = 1'b0;
      if ((in_instr[1:0] != 2'b11) || (w_fmt == FMT_INV))
         w_illegal = 1'b1;
      // R-type: only base and the SUB/SRA-style alternate encodings exist.
      if (w_fmt == FMT_R) begin
         if ((w_funct7 != 7'b0000000) && (w_funct7 != 7'b0100000))
            w_illegal = 1'b1;
         if ((w_funct7 == 7'b0100000) &&
             (w_funct3 != 3'b000) && (w_funct3 != 3'b101))
            w_illegal = 1'b1;
      end
      if ((w_opcode == OP_BRANCH) &&
          ((w_funct3 == 3'b010) || (w_funct3 == 3'b011)))
         w_illegal = 1'b1;
      // Stores: SB/SH/SW, plus SD on RV64.
      if (w_opcode == OP_STORE) begin
         if (w_funct3[2] || (!IS_RV64 && (w_funct3 == 3'b011)))
            w_illegal = 1'b1;
      end
      // Loads: LD and LWU exist only on RV64.
      if (w_opcode == OP_LOAD) begin
         if ((w_funct3 == 3'b111) ||
             (!IS_RV64 && ((w_funct3 == 3'b011) || (w_funct3 == 3'b110))))
            w_illegal = 1'b1;
      end
      if ((w_opcode == OP_JALR) && (w_funct3 != 3'b000))
         w_illegal = 1'b1;
   end
`else
   assign w_illegal = 1'b0;
`endif

   //--------------------------------------------------------------------------
   // Handshake
   //--------------------------------------------------------------------------
   assign in_ready  = !r_valid || out_ready;
   assign w_accept  = in_valid && in_ready;
   assign w_deliver = r_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_instr   <= 32'd0;
         r_pc      <= '0;
         r_rs1     <= 5'd0;
         r_rs2     <= 5'd0;
         r_rd      <= 5'd0;
         r_opcode  <= 7'd0;
         r_funct3  <= 3'd0;
         r_funct7  <= 7'd0;
         r_imm     <= '0;
         r_fmt     <= 3'd0;
         r_rd_we   <= 1'b0;
         r_illegal <= 1'b0;
         r_count   <= 32'd0;
      end else begin
         // Flush dominates any same-cycle acceptance.
         if (flush)
            r_valid <= 1'b0;
         else if (w_accept)
            r_valid <= 1'b1;
         else if (w_deliver)
            r_valid <= 1'b0;

         // Data only moves on a real acceptance, so a stall freezes it.
         if (w_accept && !flush) begin
            r_instr   <= in_instr;
            r_pc      <= in_pc;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_rd      <= w_rd;
            r_opcode  <= w_opcode;
            r_funct3  <= w_funct3;
            r_funct7  <= w_funct7;
            r_imm     <= w_imm;
            r_fmt     <= w_fmt;
            r_rd_we   <= w_rd_we;
            r_illegal <= w_illegal;
         end

         // A flushed instruction never counts as delivered.
         if (w_deliver && !flush)
            r_count <= r_count + 32'd1;
      end
   end

   assign out_valid     = r_valid;
   assign out_instr     = r_instr;
   assign out_pc        = r_pc;
   assign out_rs1       = r_rs1;
   assign out_rs2       = r_rs2;
   assign out_rd        = r_rd;
   assign out_opcode    = r_opcode;
   assign out_funct3    = r_funct3;
   assign out_funct7    = r_funct7;
   assign out_imm       = r_imm;
   assign out_fmt       = r_fmt;
   assign out_rd_we     = r_rd_we;
   assign out_illegal   = r_illegal;
   assign decoded_count = r_count;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning datapath width; legal values 32 and 64.
REQ-002 SHALL have ports clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have ports rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports flush, input, 1, which discards the held instruction.
REQ-005 SHALL have ports in_valid/in_ready, input/output, 1/1, upstream handshake.
REQ-006 SHALL have ports in_instr/in_pc, input, 32/XLEN, fetched word and its address.
REQ-007 SHALL have ports out_valid/out_ready, output/input, 1/1, downstream handshake.
REQ-008 SHALL have ports out_instr/out_pc, output, 32/XLEN, registered copies of the inputs.
REQ-009 SHALL have ports out_rs1/out_rs2/out_rd, output, 5 each, register indices.
REQ-010 SHALL have ports out_opcode/out_funct3/out_funct7, output, 7/3/7, raw instruction fields.
REQ-011 SHALL have ports out_imm, output, XLEN, sign-extended immediate.
REQ-012 SHALL have ports out_fmt, output, 3, with encoding R=0, I=1, S=2, B=3, U=4, J=5, invalid=7.
REQ-013 SHALL have ports out_rd_we/out_illegal, output, 1/1, register-write flag and illegal flag.
REQ-014 SHALL have ports decoded_count, output, 32, count of delivered instructions.

Function
REQ-015 SHALL present results one cycle after acceptance through a single output register.
- Acceptance condition: in_valid && in_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (combinational), giving full throughput with no bubble.
REQ-017 SHALL hold every out_* field stable while out_valid && !out_ready.
REQ-018 SHALL set out_valid on acceptance; otherwise it SHALL clear out_valid after a delivery (out_valid && out_ready).
REQ-019 SHALL, on flush, clear out_valid at the next edge regardless of in_valid or out_ready; flush wins over a simultaneous acceptance, and in_ready is unaffected.
REQ-020 SHALL classify the format as follows, with any other opcode classified invalid:
- R: 0110011, and 0111011 only when XLEN=64.
- I: 0010011, 0000011, 1100111, 1110011, and 0011011 only when XLEN=64.
- S: 0100011.
- B: 1100011.
- U: 0110111, 0010111.
- J: 1101111.
REQ-021 SHALL build the immediate per format, then sign-extend bit 31 of the instruction to XLEN:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R and invalid: 0.
REQ-022 SHALL set out_rd_we=1 only for R/I/U/J formats with rd!=0, and SHALL force out_rd=0 for S, B and invalid.
REQ-023 SHALL increment decoded_count by 1 on each delivery; it wraps from 0xFFFFFFFF to 0, and a flushed instruction is not counted.
REQ-024 SHALL decode purely from the instruction word, with no dependence on prior instructions.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force out_valid=0, decoded_count=0, and all out_* data fields to 0.
- Consequence of out_valid=0: in_ready=1 during reset.
REQ-026 SHALL discard, with no trace, an instruction held when reset asserts mid-operation; after deassertion the first acceptance behaves as after power-up.

Configuration
REQ-027 SHALL, with macro DECODE_ILLEGAL_CHECK_EN defined, set out_illegal=1 when any of these holds:
- instr[1:0]!=11 or out_fmt=7.
- R funct7 is not 0000000/0100000, or funct7=0100000 with funct3 not 000/101.
- B funct3 is 010/011.
- S funct3 >3, or funct3=011 when XLEN=32.
- Load funct3=111, or funct3 is 011/110 when XLEN=32.
- JALR funct3!=0.
REQ-028 SHALL, without DECODE_ILLEGAL_CHECK_EN, tie out_illegal to 0 and omit the check logic; all other outputs are identical.

Verification
REQ-029 SHALL cover, with XLEN=64, 0xFFF10093 (ADDI x1,x2,-1) -> next cycle out_valid=1, fmt=1, rd=1, rs1=2, imm=0xFFFFFFFFFFFFFFFF, rd_we=1.
REQ-030 SHALL cover 0xFE000EE3 (BEQ x0,x0,-4) -> fmt=3, imm=-4, rd=0, rd_we=0; and 0xFFFFF0B7 (LUI) -> fmt=4, imm=0xFFFFFFFFFFFFF000.
REQ-031 SHALL cover back-pressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs frozen, decoded_count unchanged; after release, one delivery per cycle.
REQ-032 SHALL cover flush and in_valid=1 in the same cycle -> out_valid=0 next cycle, and decoded_count does not increment.
REQ-033 SHALL cover, with XLEN=32, 0x0010009B (ADDIW) -> fmt=7, rd_we=0, out_illegal=1 with the macro and 0 without; and 0x0000007F -> same result.
REQ-034 SHALL cover rst_n asserted while out_valid=1 -> out_valid=0 and decoded_count=0 immediately (before the next clk edge).
